// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: sequences obstacle launches across N_SLOTS slots.
// A frame-gated gap timer, randomised by a 16-bit Galois LFSR, spaces the
// launches. The FSM picks the lowest free slot and emits a one-cycle one-hot
// launch pulse.
// Optional feature: define OBSTACLE_SCHED_SPEEDUP_EN to raise o_speed by one
// every SPEED_STEP ticks, saturating at SPEED_MAX. Without it, o_speed is fixed
// at SPEED_INIT.
module obstacle_scheduler #(
  parameter int unsigned N_SLOTS    = 3,
  parameter int unsigned MIN_GAP    = 120,
  parameter logic [7:0]  RAND_MASK  = 8'hFF,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned SPEED_INIT = 1,
  parameter int unsigned SPEED_MAX  = 4,
  parameter int unsigned SPEED_STEP = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic [N_SLOTS-1:0] i_slot_busy,
  output logic [N_SLOTS-1:0] o_spawn,
  output logic [2:0]         o_speed,
  output logic [1:0]         o_state
);

  localparam int unsigned TW = 10;
  localparam int unsigned IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_GAP       = 2'd0,
    ST_PICK      = 2'd1,
    ST_WAIT_SLOT = 2'd2,
    ST_SPAWN     = 2'd3
  } state_e;

  // Elaboration-time parameter sanity checks
  if (N_SLOTS < 1 || N_SLOTS > 8) begin : g_bad_slots
    $error("obstacle_scheduler: N_SLOTS must be 1..8");
  end
  if (MIN_GAP + 255 > 1023) begin : g_bad_gap
    $error("obstacle_scheduler: MIN_GAP + 255 must fit in 10 bits");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("obstacle_scheduler: LFSR_SEED must be nonzero");
  end

  state_e             state_q;
  logic [TW-1:0]      timer_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic [TW-1:0]      reload_d;
  logic               tick_c;
  logic               free_found_c;
  logic [IW-1:0]      free_idx_c;
  logic [N_SLOTS-1:0] spawn_vec_d;

  assign tick_c = i_ani_stb & i_animate;

  // Galois LFSR step for x^16+x^14+x^13+x^11+1; the shift keeps a nonzero state nonzero
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // Gap reload: MIN_GAP plus masked random term, held to 10 bits
  assign reload_d = TW'(MIN_GAP) + TW'(lfsr_q[7:0] & RAND_MASK);

  // Lowest-index free slot (the descending scan leaves the lowest match last)
  always_comb begin
    free_found_c = 1'b0;
    free_idx_c   = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (!i_slot_busy[k]) begin
        free_found_c = 1'b1;
        free_idx_c   = IW'(k);
      end
    end
  end

  // One-hot launch vector for the chosen slot
  always_comb begin
    spawn_vec_d = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      spawn_vec_d[k] = (free_idx_c == IW'(k));
    end
  end

  // Scheduler FSM with registered launch pulse; reset wins over everything
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_GAP;
      timer_q <= TW'(MIN_GAP);
      lfsr_q  <= LFSR_SEED;
      o_spawn <= '0;
    end else begin
      o_spawn <= '0;
      if (tick_c) begin
        lfsr_q <= lfsr_d;
      end
      case (state_q)
        ST_GAP: begin
          if (tick_c) begin
            if (timer_q == '0) begin
              state_q <= ST_PICK;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
        end
        ST_PICK: begin
          if (i_animate) begin
            if (free_found_c) begin
              state_q <= ST_SPAWN;
              o_spawn <= spawn_vec_d;
            end else begin
              state_q <= ST_WAIT_SLOT;
            end
          end
        end
        ST_WAIT_SLOT: begin
          if (i_animate && free_found_c) begin
            state_q <= ST_PICK;
          end
        end
        ST_SPAWN: begin
          // Launch lasts one cycle even when frozen; the slot is committed
          timer_q <= reload_d;
          state_q <= ST_GAP;
        end
        default: begin
          state_q <= ST_GAP;
        end
      endcase
    end
  end

  assign o_state = state_q;

`ifdef OBSTACLE_SCHED_SPEEDUP_EN
  localparam int unsigned CW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

  logic [CW-1:0] frame_cnt_q;
  logic [2:0]    speed_q;

  // Tick counter that bumps the velocity every SPEED_STEP ticks, saturating
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      speed_q     <= 3'(SPEED_INIT);
    end else if (tick_c) begin
      if (frame_cnt_q == CW'(SPEED_STEP - 1)) begin
        frame_cnt_q <= '0;
        if (speed_q < 3'(SPEED_MAX)) begin
          speed_q <= speed_q + 3'd1;
        end
      end else begin
        frame_cnt_q <= frame_cnt_q + CW'(1);
      end
    end
  end

  assign o_speed = speed_q;
`else
  assign o_speed = 3'(SPEED_INIT);
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler using a tick-level reference model.
module tb_obstacle_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_ani_stb = 1'b0;
  logic       i_animate = 1'b0;
  logic [2:0] i_slot_busy = 3'b000;
  logic [2:0] o_spawn;
  logic [2:0] o_speed;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ticks = 0;

  obstacle_scheduler dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ani_stb  (i_ani_stb),
    .i_animate  (i_animate),
    .i_slot_busy(i_slot_busy),
    .o_spawn    (o_spawn),
    .o_speed    (o_speed),
    .o_state    (o_state)
  );

  always #5 i_clk = ~i_clk;

  // One clock: drive strobe, pass the edge, sample 1 time unit later
  task automatic step(input logic stb);
    i_ani_stb = stb;
    @(posedge i_clk);
    #1;
    cyc++;
    if (stb && i_animate && !i_rst) ticks++;
  endtask

  // One strobe window: strobe on the first clock, idle for the rest
  task automatic win(input int period, output logic [2:0] sp, output int cnt,
                     output logic multi, output int sp_cyc);
    sp = '0; cnt = 0; multi = 1'b0; sp_cyc = -1;
    for (int c = 0; c < period; c++) begin
      step(c == 0);
      if (o_spawn != 3'b000) begin
        sp = sp | o_spawn;
        cnt++;
        if (!$onehot(o_spawn)) multi = 1'b1;
        sp_cyc = cyc;
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step(1'b0);
    i_rst = 1'b0;
    ticks = 0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic [2:0] lowest_free(input logic [2:0] b);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 2; k >= 0; k--) if (!b[k]) r = 3'b001 << k;
    return r;
  endfunction

  task automatic test_reset();
    i_animate = 1'b1; i_slot_busy = 3'b000;
    i_rst = 1'b1;
    step(1'b1);
    total++; if (o_spawn !== 3'b000) begin bad++; $display("FAIL reset_spawn got=%b want=000", o_spawn); end
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", o_state); end
    total++; if (o_speed !== 3'd1) begin bad++; $display("FAIL reset_speed got=%0d want=1", o_speed); end
    i_rst = 1'b0;
    ticks = 0;
  endtask

  task automatic test_first_spawn();
    logic [2:0] sp; int cnt; logic multi; int sc; logic found;
    i_animate = 1'b1; i_slot_busy = 3'b000;
    do_reset();
    found = 1'b0;
    for (int w = 0; w < 200 && !found; w++) begin
      win(4, sp, cnt, multi, sc);
      if (cnt > 0) begin
        found = 1'b1;
        total++; if (ticks !== 121) begin bad++; $display("FAIL first_spawn_tick got=%0d want=121", ticks); end
        total++; if (sp !== 3'b001) begin bad++; $display("FAIL first_spawn_slot got=%b want=001", sp); end
        total++; if (cnt !== 1) begin bad++; $display("FAIL first_spawn_width got=%0d want=1", cnt); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL first_spawn_timeout got=none want=spawn"); end
  endtask

  task automatic test_wait_slot();
    logic [2:0] sp; int cnt; logic multi; int sc; int nsp;
    i_animate = 1'b1; i_slot_busy = 3'b111;
    do_reset();
    nsp = 0;
    for (int w = 0; w < 124; w++) begin
      win(4, sp, cnt, multi, sc);
      nsp += cnt;
    end
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL wait_state got=%0d want=2", o_state); end
    total++; if (nsp !== 0) begin bad++; $display("FAIL wait_nospawn got=%0d want=0", nsp); end
    i_slot_busy = 3'b101;
    step(1'b0);
    total++; if (o_state !== 2'd1 || o_spawn !== 3'b000) begin bad++; $display("FAIL wait_pick got=%0d/%b want=1/000", o_state, o_spawn); end
    step(1'b0);
    total++; if (o_spawn !== 3'b010) begin bad++; $display("FAIL wait_spawn got=%b want=010", o_spawn); end
    step(1'b0);
    total++; if (o_spawn !== 3'b000 || o_state !== 2'd0) begin bad++; $display("FAIL wait_after got=%b/%0d want=000/0", o_spawn, o_state); end
  endtask

  task automatic test_freeze();
    logic [2:0] sp; int cnt; logic multi; int sc; int cyc0; int nsp; logic found;
    i_animate = 1'b1; i_slot_busy = 3'b000;
    do_reset();
    cyc0 = cyc;
    for (int w = 0; w < 60; w++) win(4, sp, cnt, multi, sc);
    i_animate = 1'b0;
    nsp = 0;
    for (int w = 0; w < 50; w++) begin
      win(4, sp, cnt, multi, sc);
      nsp += cnt;
      total++; if (o_state !== 2'd0) begin bad++; $display("FAIL freeze_state got=%0d want=0", o_state); end
    end
    total++; if (nsp !== 0) begin bad++; $display("FAIL freeze_nospawn got=%0d want=0", nsp); end
    i_animate = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 200 && !found; w++) begin
      win(4, sp, cnt, multi, sc);
      if (cnt > 0) begin
        found = 1'b1;
        total++; if (sc !== cyc0 + 4 * 170 + 2) begin bad++; $display("FAIL freeze_delay got=%0d want=%0d", sc - cyc0, 4 * 170 + 2); end
        total++; if (ticks !== 121) begin bad++; $display("FAIL freeze_ticks got=%0d want=121", ticks); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL freeze_timeout got=none want=spawn"); end
  endtask

  task automatic test_reset_in_spawn();
    logic [2:0] sp; int cnt; logic multi; int sc; logic found;
    i_animate = 1'b1; i_slot_busy = 3'b000;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step((i % 4) == 0);
      if (o_spawn != 3'b000) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rst_spawn_timeout got=none want=spawn"); end
    i_rst = 1'b1;
    step(1'b1);
    total++; if (o_spawn !== 3'b000) begin bad++; $display("FAIL rst_spawn_out got=%b want=000", o_spawn); end
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL rst_spawn_state got=%0d want=0", o_state); end
    total++; if (o_speed !== 3'd1) begin bad++; $display("FAIL rst_spawn_speed got=%0d want=1", o_speed); end
    i_rst = 1'b0;
    ticks = 0;
    found = 1'b0;
    for (int w = 0; w < 200 && !found; w++) begin
      win(4, sp, cnt, multi, sc);
      if (cnt > 0) begin
        found = 1'b1;
        total++; if (ticks !== 121) begin bad++; $display("FAIL rst_spawn_timer got=%0d want=121", ticks); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_spawn_resume got=none want=spawn"); end
  endtask

  task automatic test_random();
    logic [2:0] sp, exp_sp; int cnt; logic multi; int sc;
    logic [15:0] mlfsr; int mtick, next_tick, g, prev_obs, nsp, gap; logic an;
    i_animate = 1'b1; i_slot_busy = 3'b000;
    do_reset();
    mlfsr = 16'hACE1; mtick = 0; next_tick = 121; prev_obs = 0; nsp = 0;
    for (int w = 0; w < 16000 && nsp < 40; w++) begin
      an = ($urandom_range(0, 99) < 85);
      i_animate = an;
      i_slot_busy = 3'($urandom_range(0, 6));
      exp_sp = 3'b000;
      if (an) begin
        mtick++;
        mlfsr = lfsr_next(mlfsr);
        if (mtick == next_tick) begin
          exp_sp = lowest_free(i_slot_busy);
          g = 120 + int'(mlfsr[7:0]);
          next_tick = next_tick + g + 1;
        end
      end
      win(3, sp, cnt, multi, sc);
      total++; if (sp !== exp_sp) begin bad++; $display("FAIL rand_spawn win=%0d tick=%0d got=%b want=%b", w, mtick, sp, exp_sp); end
      if (sp != 3'b000) begin
        nsp++;
        total++; if (cnt !== 1 || multi) begin bad++; $display("FAIL rand_onehot got=%0d/%0b want=1/0", cnt, multi); end
        gap = ticks - prev_obs - 1;
        total++; if (gap < 120 || gap > 375) begin bad++; $display("FAIL rand_gap got=%0d want=120..375", gap); end
        prev_obs = ticks;
`ifndef OBSTACLE_SCHED_SPEEDUP_EN
        total++; if (o_speed !== 3'd1) begin bad++; $display("FAIL rand_speed got=%0d want=1", o_speed); end
`endif
      end
    end
    total++; if (nsp < 40) begin bad++; $display("FAIL rand_count got=%0d want=40", nsp); end
  endtask

  task automatic test_speed();
    int exp_s;
    i_animate = 1'b1; i_slot_busy = 3'b111;
    do_reset();
`ifdef OBSTACLE_SCHED_SPEEDUP_EN
    for (int i = 1; i <= 5000; i++) begin
      step(1'b1);
      if (i == 1023 || i == 1024 || i == 2047 || i == 2048 || i == 3071 ||
          i == 3072 || i == 4095 || i == 4096 || i == 5000) begin
        exp_s = 1 + i / 1024;
        if (exp_s > 4) exp_s = 4;
        total++; if (o_speed !== 3'(exp_s)) begin bad++; $display("FAIL speed_ramp tick=%0d got=%0d want=%0d", i, o_speed, exp_s); end
      end
    end
`else
    exp_s = 1;
    for (int i = 1; i <= 2100; i++) begin
      step(1'b1);
      if ((i % 512) == 0 || i == 1024 || i == 2048) begin
        total++; if (o_speed !== 3'(exp_s)) begin bad++; $display("FAIL speed_const tick=%0d got=%0d want=%0d", i, o_speed, exp_s); end
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_wait_slot();
    test_freeze();
    test_reset_in_spawn();
    test_random();
    test_speed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
